// File: rtl/regfile_writer_pkg.sv
// Shared CPU constants and types used by the register-file write path.
package regfile_writer_pkg;

    localparam int unsigned REG_COUNT = 32;
    localparam int unsigned REG_W     = 32;
    localparam int unsigned SEL_W     = 5;
    localparam int unsigned XZR       = 31;

    typedef logic [REG_W-1:0] reg_t;

endpackage

// File: rtl/decoder2_4.sv
// 2-to-4 one-hot decoder with enable.
//   in  : 2-bit select
//   en  : when low, all outputs are low
//   out : one-hot result
module decoder2_4 (
    input  logic [1:0] in,
    input  logic       en,
    output logic [3:0] out
);

    always_comb begin
        out = '0;
        for (int i = 0; i < 4; i++) begin
            // en gates every bit so an X select with en low still yields 0.
            out[i] = en & (in == 2'(i));
        end
    end

endmodule

// File: rtl/decoder3_8.sv
// 3-to-8 one-hot decoder with enable.
//   in  : 3-bit select
//   en  : when low, all outputs are low
//   out : one-hot result
module decoder3_8 (
    input  logic [2:0] in,
    input  logic       en,
    output logic [7:0] out
);

    always_comb begin
        out = '0;
        for (int i = 0; i < 8; i++) begin
            out[i] = en & (in == 3'(i));
        end
    end

endmodule

// File: rtl/decoder5_32.sv
// 5-to-32 one-hot decoder built from a 2-to-4 stage selecting one of four 3-to-8 stages.
//   in  : 5-bit select
//   en  : when low, all outputs are low
//   out : one-hot result, out[in] set when en is high
module decoder5_32 (
    input  logic [4:0]  in,
    input  logic        en,
    output logic [31:0] out
);

    logic [3:0] grp_en;

    decoder2_4 u_hi (
        .in  (in[4:3]),
        .en  (en),
        .out (grp_en)
    );

    for (genvar g = 0; g < 4; g++) begin : g_lo
        decoder3_8 u_lo (
            .in  (in[2:0]),
            .en  (grp_en[g]),
            .out (out[8*g +: 8])
        );
    end

endmodule

// File: rtl/regfile_writer.sv
// Register-file write port and storage, plus a one-entry record of the last committed write
// used for write-back-to-decode forwarding.
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset, clears storage and the commit record
//   wen      : write enable from write-back
//   wsel     : destination register index
//   wdata    : write-back data
//   regs     : all register contents, feeding the read-port muxes
//   wb_valid : a write was committed on the previous edge
//   wb_sel   : index of that write (qualify with wb_valid)
//   wb_data  : data of that write (qualify with wb_valid)
module regfile_writer
    import regfile_writer_pkg::*;
#(
    parameter int unsigned ZERO_REG = XZR
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wen,
    input  logic [SEL_W-1:0] wsel,
    input  reg_t             wdata,
    output reg_t             regs [REG_COUNT-1:0],
    output logic             wb_valid,
    output logic [SEL_W-1:0] wb_sel,
    output reg_t             wb_data
);

    localparam logic [REG_COUNT-1:0] ZeroMask = REG_COUNT'(1) << ZERO_REG;

    logic [REG_COUNT-1:0] dec_out;
    logic [REG_COUNT-1:0] en;
    logic                 commit;

    decoder5_32 u_dec (
        .in  (wsel),
        .en  (wen),
        .out (dec_out)
    );

    // The zero register never gets an enable, so any surviving enable is a real commit.
    assign en     = dec_out & ~ZeroMask;
    assign commit = |en;

    for (genvar i = 0; i < REG_COUNT; i++) begin : g_reg
        if (i == ZERO_REG) begin : g_zero
            assign regs[i] = '0;
        end else begin : g_ff
            reg_t reg_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    reg_q <= '0;
                end else if (en[i]) begin
                    reg_q <= wdata;
                end
            end

            assign regs[i] = reg_q;
        end
    end

    logic             wb_valid_q, wb_valid_d;
    logic [SEL_W-1:0] wb_sel_q, wb_sel_d;
    reg_t             wb_data_q, wb_data_d;

    always_comb begin
        wb_valid_d = commit;
        wb_sel_d   = wb_sel_q;
        wb_data_d  = wb_data_q;
        if (commit) begin
            wb_sel_d  = wsel;
            wb_data_d = wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_valid_q <= 1'b0;
            wb_sel_q   <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_sel_q   <= wb_sel_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_sel   = wb_sel_q;
    assign wb_data  = wb_data_q;

endmodule
